soc_pio_gpio: RTL
=================

// Module: soc_pio_gpio
// PURPOSE
//  Parametrised Avalon-MM GPIO. Successor to the fixed 8-bit output-only LED PIO.
//  Provides a WIDTH-bit output register with atomic set/clear/toggle writes.
//  Provides a synchronised WIDTH-bit input port with per-bit edge capture,
//  an interrupt mask and a level IRQ to the Nios II.
//  Sits on the SoC Avalon bus beside the other PIOs; one instance per GPIO bank.
// PARAMETERS
//  WIDTH       8     port width, 1..32; readdata bits above WIDTH read 0
//  RESET_OUT   0     reset value of the output register, WIDTH bits
//  EDGE_TYPE   0     capture edge: 0 rising, 1 falling, 2 any
//  SYNC_STAGES 2     input synchroniser depth, 2..3
// PORTS
//  clk        in   1      system clock; single clock domain
//  reset_n    in   1      asynchronous, active-low reset
//  address    in   3      word address
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe
//  writedata  in   32     write data
//  readdata   out  32     read data; combinational, zero wait states
//  in_port    in   WIDTH  asynchronous pins
//  out_port   out  WIDTH  output register
//  irq        out  1      level interrupt, active high
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - out_port=RESET_OUT; irqmask=0; edgecap=0; irq=0.
//   - Synchroniser and previous-sample flops reset to 0.
//  Write strobe we = chipselect & ~write_n. Only writedata[WIDTH-1:0] is used.
//  Address map:
//   0 DATA    R: synchronised in_port    W: out <= wd
//   1 OUTSET  R: out                     W: out <= out | wd
//   2 OUTCLR  R: out                     W: out <= out & ~wd
//   3 OUTTGL  R: out                     W: out <= out ^ wd
//   4 IRQMASK R: irqmask                 W: irqmask <= wd
//   5 EDGECAP R: edgecap                 W: W1C, edgecap <= edgecap & ~wd
//   6,7       R: 0                       W: ignored
//  Write timing: register updates on the clk edge that samples we.
//   - out_port changes 1 cycle after the write cycle.
//  Input path:
//   - SYNC_STAGES flop chain gives s; one more flop gives p.
//   - rise = s & ~p; fall = ~s & p; ev selected by EDGE_TYPE.
//   - Pin change to edgecap bit set: SYNC_STAGES+1 clk edges.
//  edgecap: edgecap <= (edgecap & ~clr) | ev, where clr is the W1C mask.
//   - An event in the same cycle as its W1C clear wins; the bit stays 1.
//  irq: registered; irq <= |(edgecap & irqmask).
//   - Rises 1 cycle after the edgecap bit and mask bit are both 1.
//   - Falls 1 cycle after the bit is cleared or masked.
//  DATA read: returns the synchronised value s, not the raw pin.
//  Reads have no side effects; edgecap clears only on an explicit W1C write.
//  Reset mid-operation: all state returns to reset values at once.
//   - Edges pending in the synchroniser are discarded.
//   - The first synchronised sample after reset does not create a fall event,
//     because p is also 0.
// STRUCTURE
//  Package soc_pio_pkg:
//   - address constants ADDR_DATA..ADDR_EDGECAP
//   - EDGE_RISE/EDGE_FALL/EDGE_ANY encodings
//  Sub-module soc_pio_edge_sync (WIDTH, SYNC_STAGES, EDGE_TYPE):
//   - synchroniser, previous-sample flop and edge selection
//   - outputs s and ev
//  Top level: register file, read mux, irq flop.
// TESTING (WIDTH=8, RESET_OUT=8'hA5, EDGE_TYPE=0 unless noted)
//  1 Reset: assert reset_n=0 mid-write -> out_port=A5, irq=0, reads of 4/5 = 0.
//  2 Atomics: wr 0<=0F, 1<=30, 2<=03, 3<=FF -> out_port 0F,3F,3C,C3, one cycle each.
//  3 Edge+irq: mask=01; in_port 00->01 -> edgecap=01 after 3 edges; irq 1 cycle later.
//    W1C 5<=01 -> edgecap=00; irq falls next cycle.
//  4 Clear collision: new rising edge on bit0 in the same cycle as W1C of bit0
//    -> edgecap[0] stays 1 and irq stays 1.
//  5 EDGE_TYPE=2: pulse in_port[3] high 4 cycles -> edgecap=08 after each edge.
//    Masked (mask=00) -> irq stays 0. Read 6 returns 0.
//  6 WIDTH=32: writedata=FFFFFFFF to 0 -> out_port all 1s; read 1 returns FFFFFFFF.

Source files
------------

// File: rtl/soc_pio_pkg.sv
// rtl/soc_pio_pkg.sv - shared constants for the GPIO PIO bank
package soc_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_OUTSET  = 3'd1;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd2;
    localparam logic [2:0] ADDR_OUTTGL  = 3'd3;
    localparam logic [2:0] ADDR_IRQMASK = 3'd4;
    localparam logic [2:0] ADDR_EDGECAP = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/soc_pio_edge_sync.sv
// rtl/soc_pio_edge_sync.sv - input synchroniser, previous-sample flop and edge select
module soc_pio_edge_sync
    import soc_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] ev
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    // prev_q also resets to 0, so a pin held high through reset yields no fall event
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

    always_comb begin
        ev = rise;
        case (EDGE_TYPE)
            EDGE_FALL: ev = fall;
            EDGE_ANY:  ev = rise | fall;
            default:   ev = rise;
        endcase
    end

endmodule

// File: rtl/soc_pio_gpio.sv
// rtl/soc_pio_gpio.sv - Avalon-MM GPIO bank with atomic output writes and edge IRQ
module soc_pio_gpio
    import soc_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic             we;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] rd_w;
    logic             irq_q;
    logic             unused_wd;

    assign we        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    soc_pio_edge_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_edge_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .pins    (in_port),
        .s       (s),
        .ev      (ev)
    );

    assign clr = (we && address == ADDR_EDGECAP) ? wd : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q     <= RESET_OUT;
            irqmask_q <= '0;
            edgecap_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (we) begin
                case (address)
                    ADDR_DATA:    out_q     <= wd;
                    ADDR_OUTSET:  out_q     <= out_q | wd;
                    ADDR_OUTCLR:  out_q     <= out_q & ~wd;
                    ADDR_OUTTGL:  out_q     <= out_q ^ wd;
                    ADDR_IRQMASK: irqmask_q <= wd;
                    default:      ;
                endcase
            end
            // OR-ing ev after the clear lets a same-cycle event survive its W1C
            edgecap_q <= (edgecap_q & ~clr) | ev;
            irq_q     <= |(edgecap_q & irqmask_q);
        end
    end

    always_comb begin
        rd_w = '0;
        case (address)
            ADDR_DATA:                           rd_w = s;
            ADDR_OUTSET, ADDR_OUTCLR, ADDR_OUTTGL: rd_w = out_q;
            ADDR_IRQMASK:                        rd_w = irqmask_q;
            ADDR_EDGECAP:                        rd_w = edgecap_q;
            default:                             rd_w = '0;
        endcase
        readdata = '0;
        readdata[WIDTH-1:0] = rd_w;
    end

    assign out_port = out_q;
    assign irq      = irq_q;

endmodule
